// File: rtl/adpll_cpu_seq_pkg.sv
// adpll_cpu_pkg: shared types and defaults for the adpll_ctr CPU-port script sequencer.
//   seq_state_t  - sequencer FSM states
//   cpu_entry_t  - one script entry {bus address, bus data} at the default bus widths
//   CPU_ADDR_W / CPU_DATA_W - default adpll_ctr CPU bus widths
package adpll_cpu_pkg;

    localparam int unsigned CPU_ADDR_W = 5;
    localparam int unsigned CPU_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_FIN
    } seq_state_t;

    typedef struct packed {
        logic [CPU_ADDR_W-1:0] addr;
        logic [CPU_DATA_W-1:0] data;
    } cpu_entry_t;

endpackage

// File: rtl/adpll_cpu_seq_tbl.sv
// adpll_cpu_seq_tbl: script register file, synchronous write, asynchronous read.
//   i_clk, i_rst  - clock, async active-high reset (clears every entry)
//   i_we, i_widx, i_wentry - write strobe, index, entry; out-of-range indices ignored
//   i_ridx, o_rentry       - combinational read port
module adpll_cpu_seq_tbl
    import adpll_cpu_pkg::*;
#(
    parameter int unsigned N_ENTRIES = 8,
    parameter type entry_t = cpu_entry_t,
    localparam int unsigned IDX_W = $clog2(N_ENTRIES)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  entry_t           i_wentry,
    input  logic [IDX_W-1:0] i_ridx,
    output entry_t           o_rentry
);

    entry_t r_mem [N_ENTRIES];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (32'(i_widx) < N_ENTRIES)) begin
            r_mem[i_widx] <= i_wentry;
        end
    end

    assign o_rentry = (32'(i_ridx) < N_ENTRIES) ? r_mem[i_ridx] : '0;

endmodule

// File: rtl/adpll_cpu_seq.sv
// adpll_cpu_seq: replays a loaded {address, data} script as handshaked writes
// on the adpll_ctr CPU port.
//   i_clk, i_rst                 - clock, async active-high reset
//   i_tbl_we/idx/addr/data       - script table load port (honoured only while idle)
//   i_n_entries, i_start         - entries to play and start request (sampled in idle)
//   i_abort                      - stop playback after the current cycle
//   o_sel/o_write/o_address/o_data_in, i_ready - bus initiator side
//   o_busy, o_done, o_err, o_wr_count          - status
module adpll_cpu_seq
    import adpll_cpu_pkg::*;
#(
    parameter int unsigned N_ENTRIES   = 8,
    parameter int unsigned ADDR_W      = CPU_ADDR_W,
    parameter int unsigned DATA_W      = CPU_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 16,
    localparam int unsigned IDX_W      = $clog2(N_ENTRIES),
    localparam int unsigned CNT_W      = $clog2(N_ENTRIES + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tbl_we,
    input  logic [IDX_W-1:0]  i_tbl_idx,
    input  logic [ADDR_W-1:0] i_tbl_addr,
    input  logic [DATA_W-1:0] i_tbl_data,
    input  logic [CNT_W-1:0]  i_n_entries,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_sel,
    output logic              o_write,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data_in,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_wr_count
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    seq_state_t        r_state;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_count;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_sel;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_data;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [CNT_W-1:0]  r_wr_count;

    logic              w_tbl_we;
    entry_t            w_wentry;
    entry_t            w_rentry;
    entry_t            w_issue;
    logic [CNT_W-1:0]  w_n_clamped;

    assign w_tbl_we = i_tbl_we && (r_state == ST_IDLE);
    assign w_wentry = '{addr: i_tbl_addr, data: i_tbl_data};

    adpll_cpu_seq_tbl #(
        .N_ENTRIES (N_ENTRIES),
        .entry_t   (entry_t)
    ) u_tbl (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_we     (w_tbl_we),
        .i_widx   (i_tbl_idx),
        .i_wentry (w_wentry),
        .i_ridx   (r_idx[IDX_W-1:0]),
        .o_rentry (w_rentry)
    );

    // The first bus cycle is registered on the same edge that accepts start,
    // so a table write to entry 0 on that edge is forwarded past the register file.
    always_comb begin
        w_issue = w_rentry;
        if (w_tbl_we && (i_tbl_idx == '0)) begin
            w_issue = w_wentry;
        end
    end

    assign w_n_clamped = (i_n_entries > CNT_W'(N_ENTRIES)) ? CNT_W'(N_ENTRIES) : i_n_entries;

    // ISSUE is the first cycle with sel high; ready is honoured there as well as
    // in WAIT so a zero-wait responder costs exactly 2 bus cycles per write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_count    <= '0;
            r_tmo      <= '0;
            r_sel      <= 1'b0;
            r_address  <= '0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_wr_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_busy     <= 1'b1;
                        r_err      <= 1'b0;
                        r_wr_count <= '0;
                        r_count    <= w_n_clamped;
                        r_idx      <= '0;
                        r_tmo      <= '0;
                        if (w_n_clamped == '0) begin
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            r_sel     <= 1'b1;
                            r_address <= w_issue.addr;
                            r_data    <= w_issue.data;
                            r_state   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (i_ready) begin
                        r_sel      <= 1'b0;
                        r_address  <= '0;
                        r_data     <= '0;
                        r_wr_count <= r_wr_count + CNT_W'(1);
                        r_idx      <= r_idx + CNT_W'(1);
                        if (i_abort) begin
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end else if (i_abort) begin
                        r_sel     <= 1'b0;
                        r_address <= '0;
                        r_data    <= '0;
                        r_done    <= 1'b1;
                        r_state   <= ST_FIN;
                    end else if (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
                        r_sel     <= 1'b0;
                        r_address <= '0;
                        r_data    <= '0;
                        r_err     <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= ST_FIN;
                    end else begin
                        r_tmo   <= r_tmo + TMO_W'(1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_GAP: begin
                    if (i_abort || (r_idx >= r_count)) begin
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_sel     <= 1'b1;
                        r_address <= w_issue.addr;
                        r_data    <= w_issue.data;
                        r_tmo     <= '0;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_sel      = r_sel;
    assign o_write    = r_sel;
    assign o_address  = r_address;
    assign o_data_in  = r_data;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_wr_count = r_wr_count;

endmodule
